neuron_mac_ctrl: RTL and testbench
==================================

Name: neuron_mac_ctrl

Overview:
- Sequences one neuron's dot product through the shared multiply unit: addresses weight and input buffers, strobes df_rdy per operand pair, waits for mu_rdy, accumulates mu_out onto a bias with signed saturation.
- Sits between the layer scheduler (start/done) and the multiply unit plus operand memories.
- Operands and results are 16-bit signed fixed point, 12 fraction bits.

Parameters:
- DATA_W, 16, operand/accumulator width (signed, Q3.12)
- ADDR_W, 8, operand buffer address width; max 2^ADDR_W inputs per neuron

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to evaluate a neuron; ignored unless busy=0
- n_in  in  ADDR_W+1  number of input/weight pairs, sampled on accepted start
- bias  in  DATA_W  accumulator initial value, sampled on accepted start
- rd_addr  out  ADDR_W  shared address to weight and input buffers (1-cycle synchronous read)
- rd_en  out  1  buffer read strobe
- df_rdy  out  1  operand-valid strobe to multiply unit
- mu_rdy  in  1  multiply result valid
- mu_out  in  DATA_W  multiply result
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, sum valid
- sum  out  DATA_W  saturated accumulation; held until next accepted start

Behaviour:
- Reset (async): state IDLE; rd_addr=0, rd_en=0, df_rdy=0, busy=0, done=0, sum=0, acc=0, idx=0.
- States: IDLE, READ, LOAD, WAIT, ACC, DONE.
- IDLE: start=1 -> latch n_in, acc=bias, idx=0, busy=1. n_in=0 -> DONE; else -> READ.
- READ: rd_addr=idx, rd_en=1 for one cycle -> LOAD.
- LOAD: buffer data valid at mu inputs; df_rdy=1 for exactly this cycle -> WAIT.
- WAIT: hold until mu_rdy=1 -> ACC. With registered multiply unit, mu_rdy arrives the cycle after df_rdy; controller tolerates any later arrival, no timeout. mu_rdy outside WAIT is ignored.
- ACC: acc = sat(acc + mu_out), computed at DATA_W+1 bits: above 0x7FFF clamps to 0x7FFF, below -0x8000 clamps to 0x8000. idx==n_in-1 -> DONE; else idx++ -> READ.
- DONE: sum=acc, done=1 one cycle, busy=1 this cycle -> IDLE.
- Per pair: 4 cycles (READ, LOAD, WAIT, ACC) with 1-cycle mu; neuron latency start->done = 4*n_in+1 cycles; n_in=0 gives done 1 cycle after start with sum=bias.
- Saturation is per step (sticky only by value), not final-only.
- start while busy ignored (no queueing). start in DONE cycle ignored.
- n_in = 2^ADDR_W: idx reaches 2^ADDR_W-1 and terminates; no address wrap.
- reset mid-operation: immediate return to reset values; sum cleared; pending mu_rdy after reset ignored.
- rd_en/df_rdy never high in same cycle; df_rdy high exactly n_in times per neuron.

Test Plan:
- n_in=3, bias=0x1000 (1.0), mu_out per pair 0x0800,0x0800,0xF800 -> done at cycle 13 after start, sum=0x1800; df_rdy pulses 3 times; rd_addr 0,1,2.
- n_in=0, bias=0xC000 -> done 1 cycle after start, sum=0xC000, no rd_en/df_rdy.
- n_in=4, bias=0x7000, each mu_out=0x0800 -> sum=0x7FFF (positive clamp); repeat with bias=0x9000, mu_out=0xF800 -> sum=0x8000.
- mu_rdy delayed 5 cycles on pair 1 of n_in=2 -> controller holds in WAIT, single accumulation per pair, latency increases by 4; spurious mu_rdy in IDLE -> acc unchanged.
- start re-asserted while busy with different n_in/bias -> ignored, original result returned; start 1 cycle after done -> accepted.
- reset asserted in WAIT of pair 2 -> outputs zero asynchronously, busy=0; new start completes correctly.

Source files
------------

// File: rtl/neuron_mac_ctrl_if.sv
// Handshake bundle between the layer scheduler / multiply unit / operand
// buffers (master side) and the neuron MAC sequencer (slave side).
interface neuron_mac_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic [ADDR_W:0]          n_in;
    logic signed [DATA_W-1:0] bias;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_en;
    logic                     df_rdy;
    logic                     mu_rdy;
    logic signed [DATA_W-1:0] mu_out;
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] sum;

    modport master (
        output start, n_in, bias, mu_rdy, mu_out,
        input  rd_addr, rd_en, df_rdy, busy, done, sum
    );

    modport slave (
        input  start, n_in, bias, mu_rdy, mu_out,
        output rd_addr, rd_en, df_rdy, busy, done, sum
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Sequences one neuron's dot product through the shared multiply unit and
// accumulates the products onto a bias with per-step signed saturation.
module neuron_mac_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input logic              clk,
    input logic              reset,
    neuron_mac_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_ACC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]        IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]          N_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Overflow shows up as a mismatch of the two top bits of the widened sum.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0]   s;
        logic signed [DATA_W-1:0] r;
        s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        if (s[DATA_W] != s[DATA_W-1]) begin
            r = s[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            r = s[DATA_W-1:0];
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [ADDR_W:0]          n_q, n_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] prod_q, prod_d;
    logic signed [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic                     rd_en_q, rd_en_d;
    logic                     df_rdy_q, df_rdy_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            sum_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            df_rdy_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            sum_q     <= sum_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            df_rdy_q  <= df_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state sequencing; outputs are decoded from the next state so they
    // leave the flops aligned with the state they belong to.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d   = bus.n_in;
                    acc_d = bus.bias;
                    idx_d = '0;
                    if (bus.n_in == {(ADDR_W+1){1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mu_rdy) begin
                    prod_d  = bus.mu_out;
                    state_d = S_ACC;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACC: begin
                acc_d = sat_add(acc_q, prod_q);
                if ({1'b0, idx_q} == (n_q - N_ONE)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_en_d   = (state_d == S_READ);
        df_rdy_d  = (state_d == S_LOAD);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        rd_addr_d = rd_en_d ? idx_d : rd_addr_q;
        sum_d     = done_d ? acc_d : sum_q;
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.df_rdy  = df_rdy_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum     = sum_q;
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Self-checking bench for neuron_mac_ctrl: a behavioural multiply-unit model
// feeds products per pair; results are checked against a plain-arithmetic model.
module tb_neuron_mac_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    neuron_mac_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    neuron_mac_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mu_val   [256];
    int          mu_delay [256];
    logic        spur_en = 1'b0;
    int          mu_cd = 0;
    logic [15:0] mu_pend = 16'h0000;

    // Multiply-unit model: product for pair k is mu_val[k], delivered
    // mu_delay[k] cycles after its df_rdy strobe.
    always @(negedge clk) begin
        if (spur_en) begin
            bus.mu_rdy = 1'b1;
            bus.mu_out = 16'($urandom);
        end else begin
            bus.mu_rdy = 1'b0;
            bus.mu_out = 16'($urandom);
            if (mu_cd > 0) begin
                mu_cd = mu_cd - 1;
                if (mu_cd == 0) begin
                    bus.mu_rdy = 1'b1;
                    bus.mu_out = mu_pend;
                end
            end
            if (bus.df_rdy) begin
                mu_cd   = mu_delay[bus.rd_addr];
                mu_pend = mu_val[bus.rd_addr];
            end
        end
    end

    int          obs_lat, obs_df, obs_done_cnt, obs_overlap, obs_addr_bad;
    logic        obs_busy_after;
    logic [15:0] obs_sum, obs_last_sum;
    int          junk_n;
    logic [15:0] junk_bias;

    function automatic logic [15:0] model_sum(input int n, input logic [15:0] b);
        int acc;
        acc = int'($signed(b));
        for (int k = 0; k < n; k++) begin
            acc = acc + int'($signed(mu_val[k]));
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
        end
        return 16'(acc);
    endfunction

    function automatic int model_lat(input int n);
        int lat;
        lat = 4 * n + 1;
        for (int k = 0; k < n; k++) lat = lat + mu_delay[k] - 1;
        return lat;
    endfunction

    task automatic set_pairs(input int n, input logic [15:0] v, input int dmax);
        for (int k = 0; k < 256; k++) begin
            mu_val[k]   = (k < n) ? v : 16'($urandom);
            mu_delay[k] = (dmax > 1) ? int'($urandom_range(1, dmax)) : 1;
        end
    endtask

    // Launches one neuron and records what the controller did; a second start
    // (junk_n/junk_bias) is pulsed restart_at cycles after the first one.
    task automatic do_neuron(input int n, input logic [15:0] b, input int restart_at);
        logic [7:0] addrs[$];
        int budget;
        budget = model_lat(n) + 30;
        obs_lat = -1; obs_df = 0; obs_done_cnt = 0; obs_overlap = 0;
        obs_addr_bad = 0; obs_busy_after = 1'b1;
        obs_sum = 16'h0000; obs_last_sum = 16'h0000;
        @(negedge clk);
        bus.start = 1'b1; bus.n_in = 9'(n); bus.bias = b;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            bus.start = (i == restart_at);
            if (bus.start) begin
                bus.n_in = 9'(junk_n); bus.bias = junk_bias;
            end else begin
                bus.n_in = 9'($urandom); bus.bias = 16'($urandom);
            end
            if (bus.rd_en) addrs.push_back(bus.rd_addr);
            if (bus.df_rdy) obs_df++;
            if (bus.rd_en && bus.df_rdy) obs_overlap++;
            if (bus.done) begin
                obs_done_cnt++;
                obs_last_sum = bus.sum;
                if (obs_lat < 0) begin
                    obs_lat = i; obs_sum = bus.sum;
                end
            end
            if (obs_lat >= 0 && i == obs_lat + 1) obs_busy_after = bus.busy;
            if (obs_lat >= 0 && i >= obs_lat + 2) break;
        end
        bus.start = 1'b0;
        if (addrs.size() != n) obs_addr_bad++;
        foreach (addrs[k]) if (int'(addrs[k]) != k) obs_addr_bad++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.n_in = '0; bus.bias = '0;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.busy, bus.done, bus.rd_en, bus.df_rdy} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b required 0000", {bus.busy, bus.done, bus.rd_en, bus.df_rdy}); else n_pass++;
        n_checks++; if (bus.sum !== 16'h0000) $display("FAIL reset_sum: got %h required 0000", bus.sum); else n_pass++;
        n_checks++; if (bus.rd_addr !== 8'h00) $display("FAIL reset_addr: got %h required 00", bus.rd_addr); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        set_pairs(3, 16'h0800, 1);
        mu_val[2] = 16'hF800;
        do_neuron(3, 16'h1000, -1);
        n_checks++; if (obs_sum !== 16'h1800) $display("FAIL basic_sum: got %h required 1800", obs_sum); else n_pass++;
        n_checks++; if (obs_lat !== 13) $display("FAIL basic_latency: got %0d required 13", obs_lat); else n_pass++;
        n_checks++; if (obs_df !== 3) $display("FAIL basic_df_count: got %0d required 3", obs_df); else n_pass++;
        n_checks++; if (obs_addr_bad !== 0) $display("FAIL basic_addr_seq: got %0d errors required 0", obs_addr_bad); else n_pass++;
        n_checks++; if (obs_overlap !== 0) $display("FAIL basic_overlap: got %0d required 0", obs_overlap); else n_pass++;
        n_checks++; if (obs_done_cnt !== 1 || obs_busy_after !== 1'b0)
            $display("FAIL basic_done_pulse: got done=%0d busy_after=%b required 1/0", obs_done_cnt, obs_busy_after); else n_pass++;
    endtask

    task automatic test_zero();
        do_neuron(0, 16'hC000, -1);
        n_checks++; if (obs_sum !== 16'hC000) $display("FAIL zero_sum: got %h required c000", obs_sum); else n_pass++;
        n_checks++; if (obs_lat !== 1) $display("FAIL zero_latency: got %0d required 1", obs_lat); else n_pass++;
        n_checks++; if (obs_df !== 0 || obs_addr_bad !== 0)
            $display("FAIL zero_no_reads: got df=%0d addr_err=%0d required 0/0", obs_df, obs_addr_bad); else n_pass++;
    endtask

    task automatic test_saturation();
        set_pairs(4, 16'h0800, 1);
        do_neuron(4, 16'h7000, -1);
        n_checks++; if (obs_sum !== 16'h7FFF) $display("FAIL sat_pos: got %h required 7fff", obs_sum); else n_pass++;
        set_pairs(4, 16'hF800, 1);
        do_neuron(4, 16'h9000, -1);
        n_checks++; if (obs_sum !== 16'h8000) $display("FAIL sat_neg: got %h required 8000", obs_sum); else n_pass++;
        set_pairs(4, 16'h0800, 1);
        mu_val[3] = 16'hF000;
        do_neuron(4, 16'h7000, -1);
        n_checks++; if (obs_sum !== model_sum(4, 16'h7000))
            $display("FAIL sat_per_step: got %h required %h", obs_sum, model_sum(4, 16'h7000)); else n_pass++;
    endtask

    task automatic test_mu_delay();
        set_pairs(2, 16'h0400, 1);
        mu_delay[1] = 5;
        do_neuron(2, 16'h0100, -1);
        n_checks++; if (obs_lat !== 13) $display("FAIL delay_latency: got %0d required 13", obs_lat); else n_pass++;
        n_checks++; if (obs_sum !== 16'h0900) $display("FAIL delay_sum: got %h required 0900", obs_sum); else n_pass++;
        @(negedge clk); spur_en = 1'b1;
        repeat (4) @(negedge clk);
        spur_en = 1'b0;
        set_pairs(1, 16'h0200, 1);
        do_neuron(1, 16'h0300, -1);
        n_checks++; if (obs_sum !== 16'h0500) $display("FAIL spurious_mu: got %h required 0500", obs_sum); else n_pass++;
    endtask

    task automatic test_start_busy();
        junk_n = 5; junk_bias = 16'h1234;
        set_pairs(3, 16'h0100, 1);
        do_neuron(3, 16'h0010, 3);
        n_checks++; if (obs_sum !== 16'h0310 || obs_done_cnt !== 1)
            $display("FAIL start_busy: got sum=%h done=%0d required 0310/1", obs_sum, obs_done_cnt); else n_pass++;
        do_neuron(3, 16'h0020, 13);
        n_checks++; if (obs_done_cnt !== 1 || obs_busy_after !== 1'b0)
            $display("FAIL start_in_done: got done=%0d busy_after=%b required 1/0", obs_done_cnt, obs_busy_after); else n_pass++;
        junk_n = 0; junk_bias = 16'h4321;
        do_neuron(3, 16'h0030, 14);
        n_checks++; if (obs_done_cnt !== 2 || obs_last_sum !== 16'h4321 || obs_sum !== 16'h0330)
            $display("FAIL start_after_done: got done=%0d sum=%h/%h required 2 0330/4321", obs_done_cnt, obs_sum, obs_last_sum); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dfs;
        set_pairs(3, 16'h0100, 1);
        mu_delay[1] = 5;
        dfs = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.n_in = 9'd3; bus.bias = 16'h0500;
        for (int i = 0; i < 40 && dfs < 2; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.df_rdy) dfs++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.rd_en, bus.df_rdy} !== 4'b0000 || bus.sum !== 16'h0000 || bus.rd_addr !== 8'h00)
            $display("FAIL reset_mid: got ctrl=%b sum=%h addr=%h required 0000/0000/00",
                     {bus.busy, bus.done, bus.rd_en, bus.df_rdy}, bus.sum, bus.rd_addr); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_pending_mu: got busy=%b required 0", bus.busy); else n_pass++;
        set_pairs(3, 16'h0200, 1);
        do_neuron(3, 16'h0050, -1);
        n_checks++; if (obs_sum !== 16'h0650 || obs_lat !== 13)
            $display("FAIL after_reset: got sum=%h lat=%0d required 0650/13", obs_sum, obs_lat); else n_pass++;
    endtask

    task automatic test_max_n();
        set_pairs(256, 16'h0000, 1);
        for (int k = 0; k < 256; k++) mu_val[k] = 16'($urandom_range(0, 255)) - 16'd128;
        do_neuron(256, 16'h0123, -1);
        n_checks++; if (obs_sum !== model_sum(256, 16'h0123))
            $display("FAIL max_n_sum: got %h required %h", obs_sum, model_sum(256, 16'h0123)); else n_pass++;
        n_checks++; if (obs_lat !== 1025 || obs_df !== 256 || obs_addr_bad !== 0)
            $display("FAIL max_n_seq: got lat=%0d df=%0d addr_err=%0d required 1025/256/0", obs_lat, obs_df, obs_addr_bad); else n_pass++;
    endtask

    task automatic test_random();
        int n, lat;
        logic [15:0] b, s;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 12));
            b = 16'($urandom);
            set_pairs(n, 16'h0000, 3);
            for (int k = 0; k < n; k++) mu_val[k] = 16'($urandom);
            s = model_sum(n, b);
            lat = model_lat(n);
            do_neuron(n, b, -1);
            n_checks++; if (obs_sum !== s) $display("FAIL rand_sum[%0d]: got %h required %h", it, obs_sum, s); else n_pass++;
            n_checks++; if (obs_lat !== lat || obs_df !== n || obs_overlap !== 0)
                $display("FAIL rand_seq[%0d]: got lat=%0d df=%0d ovl=%0d required %0d/%0d/0", it, obs_lat, obs_df, obs_overlap, lat, n); else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mu_val[k] = 16'h0000; mu_delay[k] = 1;
        end
        test_reset();
        test_basic();
        test_zero();
        test_saturation();
        test_mu_delay();
        test_start_busy();
        test_reset_mid();
        test_max_n();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
